spi_mem_bridge: RTL and testbench

SPI_MEM_BRIDGE -- requirements
Module: spi_mem_bridge

---
 rtl/spi_mem_bridge_pkg.sv | 19 +
 rtl/spi_sync.sv | 29 ++
 rtl/spi_mem_bridge.sv | 159 +++++++++++++++
 tb/tb_spi_mem_bridge.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_bridge_pkg.sv
// Shared constants for the SPI-to-memory bridge: command codes, FSM encoding
// and the default word-address width.
package spi_mem_bridge_pkg;

   localparam int DEFAULT_ADDR_W = 10;

   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      ADDR   = 3'd2,
      WDATA  = 3'd3,
      RDATA  = 3'd4,
      IGNORE = 3'd5
   } state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with a history flop
// that yields single-cycle rising/falling edge pulses in the clk domain.
module spi_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);

   // [STAGES-1] is the synchronized level, [STAGES] its one-cycle-old copy.
   logic [STAGES:0] sync_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[STAGES-1:0], din};
      end
   end

   assign q    = sync_r[STAGES-1];
   assign rise = sync_r[STAGES-1] & ~sync_r[STAGES];
   assign fall = ~sync_r[STAGES-1] & sync_r[STAGES];

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI mode-0 slave that turns 0x02/0x03 commands into word writes and
// prefetching word reads on a shared 32-bit memory port.
module spi_mem_bridge
   import spi_mem_bridge_pkg::*;
#(
   parameter int ADDR_W      = DEFAULT_ADDR_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spi_sclk,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   output logic [31:0]       mem_writedata,
   input  logic [31:0]       mem_readdata,
   output logic              busy,
   output logic              cmd_err
);

   logic sclk_q, sclk_rise, sclk_fall;
   logic cs_q, cs_rise, cs_fall;
   logic mosi_q, mosi_rise, mosi_fall;

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .reset(reset), .din(spi_sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
   );
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .reset(reset), .din(spi_cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
   );
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .reset(reset), .din(spi_mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
   );

   logic unused_sync;
   assign unused_sync = ^{sclk_q, cs_rise, mosi_rise, mosi_fall};

   state_t            state, state_nxt;
   logic [4:0]        bit_cnt;
   logic [30:0]       rx_shift;
   logic [31:0]       tx_shift;
   logic [ADDR_W-1:0] addr;
   logic              is_read;
   logic              rd_cap;
   logic              rd_req, wr_req, err_req, addr_load;
   logic [31:0]       shift_word;
   logic [ADDR_W-1:0] new_addr;

   // Word as it stands including the bit being sampled this SCLK rise.
   assign shift_word = {rx_shift, mosi_q};
   assign new_addr   = shift_word[ADDR_W-1:0];
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rd_req    = 1'b0;
      wr_req    = 1'b0;
      err_req   = 1'b0;
      addr_load = 1'b0;
      if (state != IDLE && cs_q) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:  if (cs_fall) state_nxt = CMD;
            CMD: begin
               if (sclk_rise && bit_cnt == 5'd7) begin
                  if (shift_word[7:0] == CMD_WRITE || shift_word[7:0] == CMD_READ) begin
                     state_nxt = ADDR;
                  end else begin
                     err_req   = 1'b1;
                     state_nxt = IGNORE;
                  end
               end
            end
            ADDR: begin
               if (sclk_rise && bit_cnt == 5'd15) begin
                  addr_load = 1'b1;
                  if (is_read) begin
                     rd_req    = 1'b1;
                     state_nxt = RDATA;
                  end else begin
                     state_nxt = WDATA;
                  end
               end
            end
            WDATA: if (sclk_rise && bit_cnt == 5'd31) wr_req = 1'b1;
            RDATA: if (sclk_rise && bit_cnt == 5'd31) rd_req = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt        <= '0;
         rx_shift       <= '0;
         tx_shift       <= '0;
         addr           <= '0;
         is_read        <= 1'b0;
         rd_cap         <= 1'b0;
         mem_address    <= '0;
         mem_chipselect <= 1'b0;
         mem_write      <= 1'b0;
         mem_byteenable <= 4'h0;
         mem_writedata  <= '0;
         cmd_err        <= 1'b0;
         spi_miso       <= 1'b0;
      end else begin
         cmd_err        <= err_req;
         mem_chipselect <= rd_req | wr_req;
         mem_write      <= wr_req;
         mem_byteenable <= (rd_req | wr_req) ? 4'hF : 4'h0;
         // Read data is valid the cycle after the strobe; capture it then.
         rd_cap         <= mem_chipselect & ~mem_write;

         if (state_nxt != state) begin
            bit_cnt <= '0;
         end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
         end
         if (sclk_rise) rx_shift <= shift_word[30:0];
         if (state == CMD && state_nxt == ADDR) is_read <= (shift_word[7:0] == CMD_READ);

         // addr always holds the next word to access; wraps at 2^ADDR_W.
         if (addr_load) begin
            mem_address <= new_addr;
            addr        <= rd_req ? new_addr + ADDR_W'(1) : new_addr;
         end else if (rd_req || wr_req) begin
            mem_address <= addr;
            addr        <= addr + ADDR_W'(1);
         end
         if (wr_req) mem_writedata <= shift_word;

         if (rd_cap) begin
            tx_shift <= mem_readdata;
         end else if (state == RDATA && sclk_fall) begin
            tx_shift <= {tx_shift[30:0], 1'b0};
         end
         if (state != RDATA) begin
            spi_miso <= 1'b0;
         end else if (sclk_fall) begin
            spi_miso <= tx_shift[31];
         end
      end
   end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Bench for spi_mem_bridge: bit-banged SPI master, behavioural memory, and a
// scoreboard monitor that checks memory writes and MISO words as they appear.
module tb_spi_mem_bridge;
   import spi_mem_bridge_pkg::*;

   localparam int ADDR_W = DEFAULT_ADDR_W;
   localparam int HALF   = 60;

   logic              clk = 1'b0;
   logic              reset;
   logic              spi_sclk, spi_cs_n, spi_mosi, spi_miso;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_chipselect, mem_write;
   logic [3:0]        mem_byteenable;
   logic [31:0]       mem_writedata;
   logic [31:0]       mem_readdata = '0;
   logic              busy, cmd_err;

   spi_mem_bridge #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset),
      .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata), .busy(busy), .cmd_err(cmd_err)
   );

   // clock / reset
   always #5 clk = ~clk;

   // behavioural memory: read data registered one cycle after the strobe
   logic [31:0] mem [0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) mem[mem_address] <= mem_writedata;
         else mem_readdata <= mem[mem_address];
      end
   end

   // scoreboard state
   logic [45:0] wr_exp_q[$];
   logic [31:0] rx_exp_q[$];
   logic [31:0] rx_got_q[$];
   int checks = 0;
   int passed = 0;
   int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, miso_hi_cnt = 0;
   logic prev_cs = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // monitor
   always @(negedge clk) begin
      logic [45:0] e;
      logic [31:0] g, x;
      if (!reset) begin
         if (mem_chipselect) begin
            check("strobe_gap", {63'd0, prev_cs}, 64'd0);
            if (mem_write) begin
               wr_cnt++;
               if (wr_exp_q.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_write: addr %h data %h, no write expected",
                           mem_address, mem_writedata);
               end else begin
                  e = wr_exp_q.pop_front();
                  check("write", {18'd0, mem_byteenable, mem_address, mem_writedata}, {18'd0, e});
               end
            end else begin
               rd_cnt++;
            end
         end
         prev_cs = mem_chipselect;
         if (cmd_err) err_cnt++;
         if (spi_miso === 1'b1) miso_hi_cnt++;
         while (rx_got_q.size() > 0) begin
            g = rx_got_q.pop_front();
            if (rx_exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_miso_word: got %h, none expected", g);
            end else begin
               x = rx_exp_q.pop_front();
               check("miso_word", {32'd0, g}, {32'd0, x});
            end
         end
      end
   end

   // driver tasks
   task automatic spi_bits(input logic [31:0] data, input int nbits, output logic [31:0] rx);
      rx = '0;
      for (int i = nbits - 1; i >= 0; i--) begin
         spi_mosi = data[i];
         #HALF;
         spi_sclk = 1'b1;
         rx = {rx[30:0], spi_miso};
         #HALF;
         spi_sclk = 1'b0;
      end
   endtask

   task automatic cs_low();
      @(negedge clk);
      spi_cs_n = 1'b0;
      #HALF;
   endtask

   task automatic cs_high();
      #HALF;
      spi_cs_n = 1'b1;
      #(4 * HALF);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_miso"}, {63'd0, spi_miso}, 64'd0);
      check({tag, "_cs"}, {63'd0, mem_chipselect}, 64'd0);
      check({tag, "_wr"}, {63'd0, mem_write}, 64'd0);
      check({tag, "_be"}, {60'd0, mem_byteenable}, 64'd0);
      check({tag, "_addr"}, {54'd0, mem_address}, 64'd0);
      check({tag, "_wdata"}, {32'd0, mem_writedata}, 64'd0);
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_cmd_err"}, {63'd0, cmd_err}, 64'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rx;
      int w0, r0, e0, m0, a0;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
      reset = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b0;
      repeat (8) @(negedge clk);

      // single write 0xDEADBEEF at 0x010
      w0 = wr_cnt;
      wr_exp_q.push_back({4'hF, 10'h010, 32'hDEADBEEF});
      cs_low();
      spi_bits(32'h02, 8, rx);
      check("busy_in_txn", {63'd0, busy}, 64'd1);
      spi_bits(32'h0010, 16, rx);
      spi_bits(32'hDEADBEEF, 32, rx);
      cs_high();
      check("write_count", 64'(wr_cnt - w0), 64'd1);
      check("busy_after_write", {63'd0, busy}, 64'd0);

      // read at 0x3FF, two words, wrapping to 0x000
      mem[10'h3FF] = 32'h12345678;
      mem[10'h000] = 32'hCAFEF00D;
      rx_exp_q.push_back(32'h12345678);
      rx_exp_q.push_back(32'hCAFEF00D);
      r0 = rd_cnt;
      cs_low();
      spi_bits(32'h03, 8, rx);
      spi_bits(32'h03FF, 16, rx);
      spi_bits(32'h0, 32, rx);
      rx_got_q.push_back(rx);
      spi_bits(32'h0, 32, rx);
      rx_got_q.push_back(rx);
      cs_high();
      check("read_strobes", 64'(rd_cnt - r0), 64'd3);
      check("miso_idle_after_read", {63'd0, spi_miso}, 64'd0);

      // unknown command 0x55
      e0 = err_cnt; m0 = miso_hi_cnt; a0 = wr_cnt + rd_cnt;
      cs_low();
      spi_bits(32'h55, 8, rx);
      spi_bits(32'hFFFFFF, 24, rx);
      check("busy_in_ignore", {63'd0, busy}, 64'd1);
      cs_high();
      check("cmd_err_pulses", 64'(err_cnt - e0), 64'd1);
      check("miso_quiet_bad_cmd", 64'(miso_hi_cnt - m0), 64'd0);
      check("no_access_bad_cmd", 64'(wr_cnt + rd_cnt - a0), 64'd0);

      // abort partial write, then a good write at 0x004
      w0 = wr_cnt;
      cs_low();
      spi_bits(32'h02, 8, rx);
      spi_bits(32'h0004, 16, rx);
      spi_bits(32'hABCDE, 20, rx);
      cs_high();
      check("abort_no_write", 64'(wr_cnt - w0), 64'd0);
      check("abort_busy_low", {63'd0, busy}, 64'd0);
      wr_exp_q.push_back({4'hF, 10'h004, 32'h5A5AA5A5});
      cs_low();
      spi_bits(32'h02, 8, rx);
      spi_bits(32'h0004, 16, rx);
      spi_bits(32'h5A5AA5A5, 32, rx);
      cs_high();
      check("write_after_abort", 64'(wr_cnt - w0), 64'd1);

      // reset during WDATA bit 10
      w0 = wr_cnt;
      cs_low();
      spi_bits(32'h02, 8, rx);
      spi_bits(32'h0020, 16, rx);
      spi_bits(32'h3FF, 10, rx);
      spi_mosi = 1'b1;
      #(HALF / 2);
      reset = 1'b1;
      #20;
      check_outputs_zero("mid_reset");
      #(HALF / 2 - 20);
      spi_sclk = 1'b1;
      #HALF;
      spi_sclk = 1'b0;
      reset = 1'b0;
      spi_bits(32'h1FFFFF, 21, rx);
      check("busy_after_mid_reset", {63'd0, busy}, 64'd0);
      cs_high();
      check("mid_reset_no_write", 64'(wr_cnt - w0), 64'd0);

      // 3-word burst at 0x100
      w0 = wr_cnt;
      wr_exp_q.push_back({4'hF, 10'h100, 32'h11111111});
      wr_exp_q.push_back({4'hF, 10'h101, 32'h22222222});
      wr_exp_q.push_back({4'hF, 10'h102, 32'h33333333});
      cs_low();
      spi_bits(32'h02, 8, rx);
      spi_bits(32'h0100, 16, rx);
      spi_bits(32'h11111111, 32, rx);
      spi_bits(32'h22222222, 32, rx);
      spi_bits(32'h33333333, 32, rx);
      cs_high();
      check("burst_count", 64'(wr_cnt - w0), 64'd3);

      repeat (4) @(negedge clk);
      check("wr_queue_drained", 64'(wr_exp_q.size()), 64'd0);
      check("rx_queue_drained", 64'(rx_exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
